// File: rtl/nibble_adder_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry adder exposing the carry into the MSB for overflow detection.
module nibble_adder
  import nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                c3,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c3 = c[NIBBLE_W-1];
  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract computed one nibble per cycle, LSB nibble first, through a single 4-bit adder.
module nibble_serial_adder_ctrl
  import nibble_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sub,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                     cout,
  output logic                     overflow
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [W-1:0]        a_reg;
  logic [W-1:0]        b_reg;
  logic                sub_reg;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] s_nib;
  logic                c3_nib;
  logic                co_nib;

  // Subtraction is A + ~B + 1: B is inverted per nibble and the +1 enters as the initial carry.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IDX_W'(k)) begin
        a_nib = a_reg[k*NIBBLE_W +: NIBBLE_W];
        b_nib = b_reg[k*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_reg}};
      end
    end
  end

  nibble_adder u_adder (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry),
    .s  (s_nib),
    .c3 (c3_nib),
    .co (co_nib)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sub_reg  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new request exactly like IDLE so operations can run back to back.
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
            idx     <= '0;
            carry   <= sub;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (idx == IDX_W'(k)) sum[k*NIBBLE_W +: NIBBLE_W] <= s_nib;
          end
          carry <= co_nib;
          if (idx == LAST) begin
            cout     <= co_nib;
            overflow <= c3_nib ^ co_nib;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for the nibble-serial adder: directed vector table, reset/back-to-back sequences, random ops vs. an arithmetic model.
module tb_nibble_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int tests = 0;
  int fails = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    string        name;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         c;
    logic         v;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: whole-word unsigned arithmetic, signs compared for overflow.
  function automatic void model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c, output logic v);
    int unsigned xi = int'(x);
    int unsigned yi = int'(y);
    if (!s) begin
      r = W'(xi + yi);
      c = (xi + yi) > ((1 << W) - 1);
      v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r = W'(xi - yi);
      c = (xi >= yi);
      v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
  endfunction

  // Drives a request in the current cycle, scrambles inputs during RUN, ends in the Done cycle.
  task automatic run_op(input string nm, input logic s, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic [W-1:0] es, input logic ec, input logic ev);
    start = 1'b1;
    sub   = s;
    a     = oa;
    b     = ob;
    tick();
    for (int i = 1; i <= N; i++) begin
      check({nm, " busy"}, W'(busy), W'(1'b1));
      check({nm, " done_early"}, W'(done), W'(1'b0));
      start = 1'($urandom);
      sub   = 1'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
      tick();
    end
    start = 1'b0;
    check({nm, " done"}, W'(done), W'(1'b1));
    check({nm, " busy_end"}, W'(busy), W'(1'b0));
    check({nm, " sum"}, sum, es);
    check({nm, " cout"}, W'(cout), W'(ec));
    check({nm, " ovf"}, W'(overflow), W'(ev));
  endtask

  task automatic check_idle_hold(input string nm, input logic [W-1:0] es, input logic ec, input logic ev);
    tick();
    check({nm, " done_pulse"}, W'(done), W'(1'b0));
    check({nm, " busy_idle"}, W'(busy), W'(1'b0));
    check({nm, " sum_hold"}, sum, es);
    check({nm, " cout_hold"}, W'(cout), W'(ec));
    check({nm, " ovf_hold"}, W'(overflow), W'(ev));
  endtask

  task automatic check_zero(input string nm);
    check({nm, " busy"}, W'(busy), W'(1'b0));
    check({nm, " done"}, W'(done), W'(1'b0));
    check({nm, " sum"}, sum, '0);
    check({nm, " cout"}, W'(cout), W'(1'b0));
    check({nm, " ovf"}, W'(overflow), W'(1'b0));
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    logic         rv;
    logic         rsub;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{"add_basic",  1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{"add_ripple", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"sub_borrow", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{"add_ovf",    1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{"sub_zero",   1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{"sub_ovf",    1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].c, vecs[i].v);
      check_idle_hold(vecs[i].name, vecs[i].sum, vecs[i].c, vecs[i].v);
    end

    // Reset during the second RUN cycle after nibble 0 has already been written.
    start = 1'b1;
    sub   = 1'b0;
    a     = 16'h00F7;
    b     = 16'h0001;
    tick();
    start = 1'b0;
    tick();
    check("midrun busy", W'(busy), W'(1'b1));
    check("midrun sum_nib0", W'(sum[3:0]), W'(4'h8));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("midrun_reset");
    tick();
    check_zero("after_reset_idle");
    run_op("post_reset", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
    check_idle_hold("post_reset", 16'h0002, 1'b0, 1'b0);

    // Back-to-back: the second request is presented in the Done cycle of the first.
    run_op("b2b_first", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
    run_op("b2b_second", 1'b0, 16'h00F0, 16'h0010, 16'h0100, 1'b0, 1'b0);
    check_idle_hold("b2b_second", 16'h0100, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rsub = 1'($urandom);
      ra   = W'($urandom);
      rb   = W'($urandom);
      if (n % 8 == 0) rb = ra;
      if (n % 8 == 1) rb = ~ra;
      model(rsub, ra, rb, rs, rc, rv);
      run_op("rand", rsub, ra, rb, rs, rc, rv);
      if ($urandom_range(0, 1) == 1) check_idle_hold("rand", rs, rc, rv);
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs wide add/subtract by time-multiplexing one 4-bit ripple-carry nibble adder, least-significant nibble first.
- Carry is registered between cycles.
- Sits between switch/register operand sources and LED/7-seg result displays on the DE2 exercise boards.
- Trades NIBBLES cycles of latency for a single 4-bit adder datapath.

Parameters:
- NIBBLES, 4, operand width in nibbles (operand width W = 4*NIBBLES); legal range 1..16.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE or DONE.
- Sub  in  1  0 = A+B, 1 = A-B; captured with Start.
- A  in  W  operand A; captured with Start.
- B  in  W  operand B; captured with Start.
- Busy  out  1  high while nibbles are being processed.
- Done  out  1  one-cycle pulse when the result becomes valid.
- Sum  out  W  result; held stable from Done until the next accepted Start.
- Cout  out  1  carry out of MSB; for Sub=1 this is the no-borrow flag (1 = A>=B unsigned).
- Overflow  out  1  two's-complement overflow of the W-bit result.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (synchronous, active-high, any state including mid-RUN) forces:
  - state=IDLE, nibble index=0, carry reg=0
  - Busy=0, Done=0, Sum=0, Cout=0, Overflow=0
  - operand registers cleared
- IDLE, Start=1 at edge t: capture A, B, Sub; index=0; carry reg=Sub; state->RUN. Start=0: remain in IDLE.
- RUN: each cycle processes nibble k=index:
  - adder inputs: a=Areg[4k+3:4k], b=Breg[4k+3:4k] XOR {4{Subreg}}, ci=carry reg
  - Sum[4k+3:4k]<=s; carry reg<=co; index<=index+1
  - on k=NIBBLES-1: Cout<=co; Overflow<=c3^co, where c3 is the carry into bit 3 of that nibble; state->DONE
- Busy=1 exactly during RUN cycles; Start is ignored while in RUN.
- Timing: if Start is accepted at edge t, Busy is high t+1..t+NIBBLES and Done is high for the single cycle t+NIBBLES+1. Latency Start->Done = NIBBLES+1 cycles.
- DONE: Done=1 for one cycle. Start=1 in this cycle is accepted as in IDLE, giving back-to-back operation with no idle gap; otherwise state->IDLE.
- Sum, Cout and Overflow hold their values through IDLE. Sum nibbles update progressively during RUN and are valid only once Done is asserted.
- Index width: clog2(NIBBLES), minimum 1 bit. Index never exceeds NIBBLES-1.
- Arithmetic is modulo 2^W; wrap-around is expected and is flagged only via Cout/Overflow.
- Changes to A, B or Sub after capture have no effect on an operation in progress.

Decomposition:
- Package nibble_adder_pkg:
  - NIBBLE_W=4
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
- Sub-module nibble_adder:
  - purely combinational 4-bit ripple adder
  - ports: a[3:0], b[3:0], ci -> s[3:0], c3 (carry into bit 3), co
  - one instance in the controller

Test Plan:
- NIBBLES=4, Sub=0, A=16'h1234, B=16'h0FFF, Start pulse -> Busy high 4 cycles, Done at t+5, Sum=16'h2233, Cout=0, Overflow=0.
- A=16'hFFFF, B=16'h0001, Sub=0 -> Sum=16'h0000, Cout=1, Overflow=0 (carry ripples through all 4 nibble cycles).
- Sub=1, A=16'h0005, B=16'h0007 -> Sum=16'hFFFE, Cout=0, Overflow=0. Then A=16'h8000, B=16'h0001, Sub=1 -> Sum=16'h7FFF, Cout=1, Overflow=1.
- A=16'h7FFF, B=16'h0001, Sub=0 -> Sum=16'h8000, Overflow=1. Start re-pulsed and A changed during RUN -> ignored, result unchanged.
- Reset asserted in 2nd RUN cycle -> next cycle state IDLE, all outputs 0. Following Start with A=16'h0001, B=16'h0001 -> Sum=16'h0002 with correct latency (no stale carry).
- Start held high in DONE with new operands A=16'h00F0, B=16'h0010 -> accepted immediately, Busy rises next cycle, second Done 5 cycles after the first, Sum=16'h0100.
